// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display blocks: segment encoding and scan state.
package seven_seg_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Value-logic side (digit values, enables, load) and pin side (selects, segments, frame pulse).
interface seven_seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digit_values;
  logic [N_DIGITS-1:0]   digit_enable;
  logic                  load;
  logic [N_DIGITS-1:0]   digit;
  logic [6:0]            segments;
  logic                  frame_done;

  modport master (
    output digit_values, digit_enable, load,
    input  digit, segments, frame_done
  );

  modport slave (
    input  digit_values, digit_enable, load,
    output digit, segments, frame_done
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan of an N-digit common-anode display with per-slot blanking
// and frame-synchronous (tear-free) value updates.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                  clock,
  input logic                  reset,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  scan_state_t   state_q, state_d;
  logic          wrap, boundary;

  logic [N_DIGITS-1:0][3:0] pend_val, shad_val;
  logic [N_DIGITS-1:0]      pend_en, shad_en;
  logic                     pend_flag;
  logic [N_DIGITS-1:0][6:0] dec;

  logic [N_DIGITS-1:0] digit_d, digit_q;
  logic [6:0]          seg_d, seg_q;
  logic [1:0]          fd_pipe;

  // One decoder per digit keeps the output mux a plain select on idx
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    hex_to_seg7 u_dec (
      .nibble (shad_val[g]),
      .seg    (dec[g])
    );
  end

  assign wrap     = (cnt_q == CNT_LAST);
  assign boundary = wrap && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    digit_d = '1;
    seg_d   = SEG_OFF;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    case (state_q)
      BLANK: begin
        if (cnt_d >= CNT_SHOW) state_d = SHOW;
      end
      SHOW: begin
        if (wrap) state_d = BLANK;
        // A disabled digit keeps its select low but lights nothing
        digit_d[idx_q] = 1'b0;
        if (shad_en[idx_q]) seg_d = dec[idx_q];
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_val  <= '0;
      pend_en   <= '0;
      pend_flag <= 1'b0;
      shad_val  <= '0;
      shad_en   <= '0;
      digit_q   <= '1;
      seg_q     <= SEG_OFF;
      fd_pipe   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      // Boundary is seen on the last counter cycle; the output lags one more clock
      fd_pipe <= {fd_pipe[0], boundary};
      if (bus.load) begin
        pend_val <= bus.digit_values;
        pend_en  <= bus.digit_enable;
      end
      if (boundary) begin
        pend_flag <= 1'b0;
        if (bus.load) begin
          shad_val <= bus.digit_values;
          shad_en  <= bus.digit_enable;
        end else if (pend_flag) begin
          shad_val <= pend_val;
          shad_en  <= pend_en;
        end
      end else if (bus.load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  assign bus.digit      = digit_q;
  assign bus.segments   = seg_q;
  assign bus.frame_done = fd_pipe[1];

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: table vectors with hand-decoded segments, corner
// sequences, and random loads checked every cycle against a frame-level model.
module tb_seven_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int P  = 8;
  localparam int BC = 2;
  localparam int NP = N * P;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seven_seg_scan_ctrl_if #(.N_DIGITS(N)) bus ();

  seven_seg_scan_ctrl #(
    .N_DIGITS     (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (BC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int              t;
    logic [4*N-1:0]  vals;
    logic [N-1:0]    en;
  } load_t;

  typedef struct {
    logic [4*N-1:0]    vals;
    logic [N-1:0]      en;
    logic [N-1:0][6:0] seg;   // expected pattern per digit, digit 0 in the low slot
  } vec_t;

  load_t loads[$];
  vec_t  tbl[6];
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int t = 0;
  bit in_rst = 1'b1;
  int total = 0;
  int bad = 0;

  // Edge t after release shows the scan position t-1. Frame f is shown with the
  // latest load sampled on or before edge f*NP (the boundary edge).
  function automatic void exp_out(output logic [N-1:0] d, output logic [6:0] s, output logic fd);
    int p, slot, off, f;
    logic [4*N-1:0] v;
    logic [N-1:0]   e;
    d = '1; s = 7'h7F; fd = 1'b0;
    if (in_rst || t == 0) return;
    p = t - 1; slot = (p / P) % N; off = p % P; f = p / NP;
    v = '0; e = '0;
    foreach (loads[i]) if (loads[i].t <= f * NP) begin v = loads[i].vals; e = loads[i].en; end
    fd = (t > 1) && (p % NP == 0);
    if (off >= BC) begin
      d[slot] = 1'b0;
      s = e[slot] ? lut[v[slot*4 +: 4]] : 7'h7F;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit ld, input logic [4*N-1:0] v, input logic [N-1:0] e);
    logic [N-1:0] ed;
    logic [6:0]   es;
    logic         efd;
    reset = rst; bus.load = ld; bus.digit_values = v; bus.digit_enable = e;
    @(posedge clock);
    if (rst) begin in_rst = 1'b1; t = 0; loads.delete(); end
    else begin
      in_rst = 1'b0; t++;
      if (ld) loads.push_back('{t, v, e});
    end
    #1;
    exp_out(ed, es, efd);
    check("digit", 32'(bus.digit), 32'(ed));
    check("segments", 32'(bus.segments), 32'(es));
    check("frame_done", 32'(bus.frame_done), 32'(efd));
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  // Advance until the next edge will be edge number m (mod NP)
  task automatic align(input int m);
    for (int k = 0; k < NP && ((t + 1) % NP) != m; k++) cycle(1'b0, 1'b0, '0, '0);
  endtask

  // Check every SHOW cycle of frame ft against constant per-digit patterns
  task automatic check_frame(input string name, input int ft, input logic [N-1:0][6:0] seg);
    int p;
    for (int k = 0; k < 3 * NP; k++) begin
      cycle(1'b0, 1'b0, '0, '0);
      p = t - 1;
      if (p / NP == ft && p % P >= BC) check(name, 32'(bus.segments), 32'(seg[(p / P) % N]));
      if (p / NP > ft) break;
    end
  endtask

  initial begin
    int ft, nfd;
    tbl[0] = '{16'h1234, 4'hF,    {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[1] = '{16'h00AB, 4'b0011, {7'h7F, 7'h7F, 7'h08, 7'h03}};
    tbl[2] = '{16'h2222, 4'hF,    {7'h24, 7'h24, 7'h24, 7'h24}};
    tbl[3] = '{16'hCDEF, 4'hF,    {7'h46, 7'h21, 7'h06, 7'h0E}};
    tbl[4] = '{16'h5678, 4'b1010, {7'h12, 7'h7F, 7'h78, 7'h7F}};
    tbl[5] = '{16'h90A0, 4'hF,    {7'h10, 7'h40, 7'h08, 7'h40}};
    bus.load = 1'b0; bus.digit_values = '0; bus.digit_enable = '0;

    // Reset values, then two blank frames with the scan pattern checked by the model
    cycle(1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0);
    check("reset_digit", 32'(bus.digit), 32'hF);
    check("reset_seg", 32'(bus.segments), 32'h7F);
    check("reset_fd", 32'(bus.frame_done), 32'h0);
    idle(3);
    check("first_show", 32'(bus.digit), 32'hE);
    idle(2 * NP);

    // Table vectors, each loaded mid-frame and checked on the frame after the boundary
    foreach (tbl[i]) begin
      align(NP / 2 + i);
      cycle(1'b0, 1'b1, tbl[i].vals, tbl[i].en);
      ft = (t + NP - 1) / NP;
      check_frame("tbl_seg", ft, tbl[i].seg);
    end

    // Two loads in one frame: only the later one is shown
    align(5);
    cycle(1'b0, 1'b1, 16'h1111, 4'hF);
    idle(6);
    cycle(1'b0, 1'b1, 16'h2222, 4'hF);
    ft = (t + NP - 1) / NP;
    check_frame("last_load_wins", ft, {7'h24, 7'h24, 7'h24, 7'h24});

    // Load sampled on the boundary edge takes effect in the frame that starts there
    align(0);
    cycle(1'b0, 1'b1, 16'h7777, 4'hF);
    check_frame("boundary_load", t / NP, {7'h78, 7'h78, 7'h78, 7'h78});
    idle(NP);

    // frame_done: exactly one pulse per frame
    nfd = 0;
    for (int k = 0; k < 3 * NP; k++) begin
      cycle(1'b0, 1'b0, '0, '0);
      if (bus.frame_done === 1'b1) nfd++;
    end
    check("fd_count", 32'(nfd), 32'd3);

    // Reset during SHOW of digit 2: scan restarts at digit 0 with a blank shadow
    align(2 * P + 5);
    cycle(1'b0, 1'b0, '0, '0);
    check("pre_reset_digit", 32'(bus.digit), 32'hB);
    cycle(1'b1, 1'b0, '0, '0);
    check("midreset_digit", 32'(bus.digit), 32'hF);
    check("midreset_seg", 32'(bus.segments), 32'h7F);
    idle(2 * NP);

    // Random loads, values and enables; the model checks every cycle
    for (int k = 0; k < 800; k++)
      cycle(1'b0, ($urandom_range(0, 15) == 0), 16'($urandom), 4'($urandom));
    idle(2 * NP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
